// File: rtl/diff_pkg.sv
// -----------------------------------------------------------------------------
// diff_pkg
// Shared definitions for the diff_scan_unit slice:
//   - mode encodings (MODE_LOW / MODE_HIGH / MODE_POP; 2'b11 executes as LOW)
//   - FSM state type (IDLE / SCAN / DONE)
//   - calc_rw(): result width derivation, $clog2(WIDTH)+1, which is wide
//     enough to hold both the WIDTH sentinel and a full popcount.
// -----------------------------------------------------------------------------
package diff_pkg;

  localparam logic [1:0] MODE_LOW  = 2'b00;
  localparam logic [1:0] MODE_HIGH = 2'b01;
  localparam logic [1:0] MODE_POP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_rw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/diff_chunk_scan.sv
// -----------------------------------------------------------------------------
// diff_chunk_scan
// Combinational analysis of one CHUNK-bit slice of the XOR word.
// Ports:
//   chunk   in   CHUNK bits of the XOR word
//   any     out  at least one bit of the chunk is set
//   lo_idx  out  index of the lowest set bit within the chunk (0 if none)
//   hi_idx  out  index of the highest set bit within the chunk (0 if none)
//   popcnt  out  number of set bits in the chunk
// -----------------------------------------------------------------------------
module diff_chunk_scan #(
  parameter  int CHUNK = 8,
  localparam int IW    = (CHUNK > 1) ? $clog2(CHUNK) : 1,
  localparam int PCW   = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] chunk,
  output logic             any,
  output logic [IW-1:0]    lo_idx,
  output logic [IW-1:0]    hi_idx,
  output logic [PCW-1:0]   popcnt
);

  always_comb begin
    // NOTE: every output gets a default before the loops; otherwise a path
    // that never assigns it would infer a latch.
    any    = |chunk;
    lo_idx = '0;
    hi_idx = '0;
    popcnt = '0;
    // Downward walk: the last hit written is the lowest set bit.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) lo_idx = IW'(i);
    end
    // Upward walk: the last hit written is the highest set bit.
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) hi_idx = IW'(i);
      popcnt = popcnt + PCW'(chunk[i]);
    end
  end

endmodule

// File: rtl/diff_scan_unit.sv
// -----------------------------------------------------------------------------
// diff_scan_unit
// Multi-cycle bit-difference unit. Captures x = in1 ^ in2 and scans it CHUNK
// bits per cycle to report the lowest differing bit (LOW), the highest
// differing bit (HIGH) or the Hamming distance (POP). LOW/HIGH report WIDTH
// when the operands are identical.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   in1, in2             WIDTH-bit operands
//   mode                 00 LOW, 01 HIGH, 10 POP, 11 treated as LOW
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   result               bit index, WIDTH sentinel, or popcount
//   eq                   operands were identical
// Configuration macro:
//   DIFF_SCAN_EARLY_EXIT_EN  when defined, LOW/HIGH finish on the cycle that
//                            finds the first non-zero chunk; otherwise every
//                            operation takes exactly NCHUNK scan cycles.
// -----------------------------------------------------------------------------
module diff_scan_unit
  import diff_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in1,
  input  logic [WIDTH-1:0]          in2,
  input  logic [1:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [calc_rw(WIDTH)-1:0] result,
  output logic                      eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int RW     = calc_rw(WIDTH);
  localparam int PW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int PCW    = $clog2(CHUNK) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q;
  logic [1:0]       mode_q;
  logic [PW-1:0]    ptr_q;
  logic             found_q;
  logic [RW-1:0]    idx_q;
  logic [RW-1:0]    count_q;

  // ---------------------------------------------------------------------------
  // Current chunk analysis
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] chunk;
  logic             c_any;
  logic [IW-1:0]    c_lo, c_hi;
  logic [PCW-1:0]   c_pop;

  assign chunk = x_q[int'(ptr_q)*CHUNK +: CHUNK];

  diff_chunk_scan #(.CHUNK(CHUNK)) u_chunk_scan (
    .chunk  (chunk),
    .any    (c_any),
    .lo_idx (c_lo),
    .hi_idx (c_hi),
    .popcnt (c_pop)
  );

  logic          is_high, is_pop, hit, last_chunk, scan_done, found_nx;
  logic [RW-1:0] idx_nx, count_nx;

  always_comb begin
    is_high    = (mode_q == MODE_HIGH);
    is_pop     = (mode_q == MODE_POP);
    // Only the first non-zero chunk in scan order may set the index.
    hit        = c_any && !found_q && !is_pop;
    found_nx   = found_q | hit;
    idx_nx     = hit ? RW'(int'(ptr_q)*CHUNK) + RW'(is_high ? c_hi : c_lo) : idx_q;
    count_nx   = count_q + RW'(c_pop);
    last_chunk = is_high ? (ptr_q == '0) : (ptr_q == PW'(NCHUNK - 1));
`ifdef DIFF_SCAN_EARLY_EXIT_EN
    scan_done  = last_chunk || hit;
`else
    scan_done  = last_chunk;
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        if (scan_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, pointer, accumulators, held result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset (there is no memory here), so
    // result and eq can never be X, even before the first operation.
    if (!rst_n) begin
      x_q     <= '0;
      mode_q  <= MODE_LOW;
      ptr_q   <= '0;
      found_q <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      result  <= '0;
      eq      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= in1 ^ in2;
            mode_q  <= (mode == MODE_HIGH || mode == MODE_POP) ? mode : MODE_LOW;
            ptr_q   <= (mode == MODE_HIGH) ? PW'(NCHUNK - 1) : '0;
            found_q <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
          end
        end
        SCAN: begin
          found_q <= found_nx;
          idx_q   <= idx_nx;
          count_q <= count_nx;
          ptr_q   <= is_high ? ptr_q - PW'(1) : ptr_q + PW'(1);
          // Result is frozen on entry to DONE so it is stable under backpressure.
          if (scan_done) begin
            result <= is_pop ? count_nx : (found_nx ? idx_nx : RW'(WIDTH));
            eq     <= (x_q == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_diff_scan_unit.sv
// -----------------------------------------------------------------------------
// tb_diff_scan_unit
// Directed bench for diff_scan_unit with WIDTH=32, CHUNK=8 (RW=6).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_diff_scan_unit;
  import diff_pkg::*;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int RW    = 6;
  localparam int TMO   = 20;

`ifdef DIFF_SCAN_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1, in2;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;
  logic             eq;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen_valid;

  always #5 clk = ~clk;

  diff_scan_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .eq        (eq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation at a falling edge, let it be accepted, then count
  // rising edges until out_valid shows up (bounded by TMO).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] m, input string tag);
    in1      = a;
    in2      = b;
    mode     = m;
    in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string tag, input int exp_lat,
                               input logic [RW-1:0] exp_res, input logic exp_eq);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".eq"}, 32'(eq), 32'(exp_eq));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    mode      = MODE_LOW;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.eq", 32'(eq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOW: x=0xE0 -> lowest bit 5, found in chunk 0
    run_op(32'h0000_00F0, 32'h0000_0010, MODE_LOW, "low");
    expect_result("low", EARLY ? 1 : 4, 6'd5, 1'b0);
    handshake("low");

    // HIGH: x=0x80000000 -> 31, found in the first chunk scanned (chunk 3)
    run_op(32'h8000_0001, 32'h0000_0001, MODE_HIGH, "high");
    expect_result("high", EARLY ? 1 : 4, 6'd31, 1'b0);
    handshake("high");

    // POP: all ones -> 32
    run_op(32'hFFFF_FFFF, 32'h0000_0000, MODE_POP, "pop");
    expect_result("pop", 4, 6'd32, 1'b0);
    handshake("pop");

    // POP on a sparse pattern: 0x0F0300A1 -> 4+2+0+3 = 9
    run_op(32'h0F03_00A1, 32'h0000_0000, MODE_POP, "pop_sparse");
    expect_result("pop_sparse", 4, 6'd9, 1'b0);
    handshake("pop_sparse");

    // Equal operands in every mode
    run_op(32'h1234_5678, 32'h1234_5678, MODE_LOW, "eq_low");
    expect_result("eq_low", 4, 6'd32, 1'b1);
    handshake("eq_low");
    run_op(32'h1234_5678, 32'h1234_5678, MODE_HIGH, "eq_high");
    expect_result("eq_high", 4, 6'd32, 1'b1);
    handshake("eq_high");
    run_op(32'h1234_5678, 32'h1234_5678, MODE_POP, "eq_pop");
    expect_result("eq_pop", 4, 6'd0, 1'b1);
    handshake("eq_pop");
    run_op(32'h1234_5678, 32'h1234_5678, 2'b11, "eq_m11");
    expect_result("eq_m11", 4, 6'd32, 1'b1);
    handshake("eq_m11");

    // Reserved mode on non-zero data: x=0x00010100 -> LOW gives 8 (HIGH would be 16)
    run_op(32'h0001_0100, 32'h0000_0000, 2'b11, "m11");
    expect_result("m11", EARLY ? 2 : 4, 6'd8, 1'b0);
    handshake("m11");

    // HIGH on a middle chunk: x=0x00F00000 -> 23, found in chunk 2
    run_op(32'h00F0_0000, 32'h0000_0000, MODE_HIGH, "high_mid");
    expect_result("high_mid", EARLY ? 2 : 4, 6'd23, 1'b0);
    handshake("high_mid");

    // Backpressure: hold out_ready low with new operands pending
    run_op(32'h0000_00F0, 32'h0000_0010, MODE_LOW, "bp");
    expect_result("bp", EARLY ? 1 : 4, 6'd5, 1'b0);
    in1      = 32'hFFFF_FFFF;
    in2      = 32'h0000_0000;
    mode     = MODE_POP;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.result", 32'(result), 32'd5);
      check("bp.eq", 32'(eq), 32'd0);
      check("bp.in_ready", 32'(in_ready), 32'd0);
    end
    handshake("bp");
    // Pending operands are accepted only now
    run_op(32'hFFFF_FFFF, 32'h0000_0000, MODE_POP, "bp_next");
    expect_result("bp_next", 4, 6'd32, 1'b0);
    handshake("bp_next");

    // Reset during the 2nd SCAN cycle (lowest set bit is in the last chunk)
    in1      = 32'h8000_0000;
    in2      = 32'h0000_0000;
    mode     = MODE_LOW;
    in_valid = 1'b1;
    @(posedge clk);           // acceptance
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);           // first chunk processed
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    check("rst_mid.result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("rst_mid.no_pulse", 32'(seen_valid), 32'd0);
    run_op(32'h0000_0100, 32'h0000_0000, MODE_LOW, "post_rst");
    expect_result("post_rst", EARLY ? 2 : 4, 6'd8, 1'b0);
    handshake("post_rst");

    // Early-exit cases (fixed latency of 4 when the feature is off)
    run_op(32'h0000_0008, 32'h0000_0000, MODE_LOW, "ee_low");
    expect_result("ee_low", EARLY ? 1 : 4, 6'd3, 1'b0);
    handshake("ee_low");
    run_op(32'h0000_0008, 32'h0000_0000, MODE_HIGH, "ee_high");
    expect_result("ee_high", 4, 6'd3, 1'b0);
    handshake("ee_high");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/diff_scan_unit.md
# diff_scan_unit

Parametrised, multi-cycle successor to the combinational bit-difference operator in the ALU datapath. Takes two WIDTH-bit operands and reports one of three results over a valid/ready handshake: the index of the lowest differing bit, the index of the highest differing bit, or the Hamming distance. The XOR word is scanned CHUNK bits per cycle, so wide operands do not need a full-width priority encoder. It sits beside the ALU as a multi-cycle functional unit.

## Interface
- WIDTH, 32: operand width. Must be ≥2 and a multiple of CHUNK.
- CHUNK, 8: bits examined per scan cycle. Must be a power of two.
- Derived: NCHUNK = WIDTH/CHUNK; RW = $clog2(WIDTH)+1, the result width.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  unit can accept (high only in IDLE).
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- mode  input  2  operation select: 00 LOW, 01 HIGH, 10 POP, 11 reserved (executes as LOW).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  RW  bit index or popcount.
- eq  output  1  operands were identical (XOR == 0).

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: register x=in1^in2 and mode, clear the accumulators, load the chunk pointer, go to SCAN.
  - Chunk pointer start: 0 for LOW/POP, NCHUNK-1 for HIGH.
- **SCAN**
  - Each cycle examines chunk x[ptr*CHUNK +: CHUNK].
  - LOW: the first chunk with any bit set latches found=1 and idx = ptr*CHUNK + lowest set bit. Later chunks are ignored. ptr increments.
  - HIGH: the same with the highest set bit, scanning downward. ptr decrements.
  - POP: adds the chunk popcount to the count.
  - After the NCHUNK-th chunk, go to DONE.
- **DONE**
  - out_valid=1.
  - result is held stable:
    - LOW/HIGH: idx, or WIDTH if nothing was found.
    - POP: count.
  - eq = (x == 0) in all modes.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0 in DONE. A new operation is accepted no earlier than the cycle after the output handshake.
- **Inputs outside IDLE**: in_valid, in1, in2 and mode are ignored in SCAN and DONE.
- **No undefined outputs**: result and eq are never X, and the WIDTH sentinel replaces the old default-X behaviour.
- **Arithmetic**: the popcount accumulator is RW bits wide. The maximum value, WIDTH, fits without overflow.

## Timing
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, so in_ready=1.
  - out_valid=0, result=0, eq=0.
  - All internal registers 0.
- Reset mid-SCAN or mid-DONE aborts the operation. The result is discarded and no out_valid pulse occurs.
- Latency without early exit:
  - Acceptance edge E0; chunks are processed on E1..E(NCHUNK).
  - out_valid rises after E(NCHUNK), i.e. exactly NCHUNK cycles after acceptance, for every mode and any data.
- Throughput: one operation per NCHUNK+2 cycles at best (accept, NCHUNK scan cycles, output handshake).
- Backpressure: out_valid, result and eq stay unchanged while out_ready=0, for any duration.

## Configuration
- DIFF_SCAN_EARLY_EXIT_EN
  - **Defined:** in LOW/HIGH mode, SCAN moves to DONE on the same edge that finds the first set chunk. Latency = (number of chunks examined) cycles, minimum 1. POP mode and eq=1 cases still take NCHUNK cycles.
  - **Undefined:** fixed NCHUNK-cycle latency in all modes, for deterministic scheduling.

## Structure
- **Package diff_pkg:**
  - mode encoding constants: MODE_LOW, MODE_HIGH, MODE_POP.
  - state typedef: IDLE/SCAN/DONE.
  - RW derivation function.
- **Sub-module diff_chunk_scan** (combinational, parameter CHUNK):
  - input: one chunk.
  - outputs: any, lo_idx, hi_idx, popcnt.
- The top level holds the FSM, the pointer, the accumulators and the handshake.

## Test plan
All cases use WIDTH=32, CHUNK=8.
- **LOW:** in1=0x000000F0, in2=0x00000010 → result=5, eq=0; out_valid exactly 4 cycles after acceptance (early exit off).
- **HIGH:** in1=0x80000001, in2=0x00000001 → result=31, eq=0. **POP:** in1=0xFFFFFFFF, in2=0 → result=32, eq=0.
- **Equal operands:** in1=in2=0x12345678 → LOW/HIGH result=32, eq=1; POP result=0, eq=1; mode=11 behaves as LOW.
- **Backpressure:** hold out_ready=0 for 5 cycles while driving in_valid=1 with new data → out_valid, result and eq stay stable, in_ready=0, and the new data is not captured until after the handshake.
- **Reset mid-operation:** rst_n low during the 2nd SCAN cycle → out_valid=0, in_ready=1 immediately. After release, in1=0x00000100, in2=0 in LOW → result=8.
- **Early exit (DIFF_SCAN_EARLY_EXIT_EN defined):**
  - LOW with x=0x00000008 → out_valid 1 cycle after acceptance, result=3.
  - HIGH with x=0x00000008 → 4 cycles, result=3.
